dds_wave_engine: RTL and testbench

Parametrised waveform lookup engine for the DDS datapath, placed between the phase accumulator and the DAC interface. It maps a phase address to one of four waveforms: cosine, pulse with programmable duty, triangle, or a double-buffered user AWG table. Mode, duty and AWG bank changes take effect only at a phase wrap, so output transitions are glitch-free.

---
 rtl/dds_wave_engine.sv | 166 ++++++++++++++++
 tb/tb_dds_wave_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_wave_engine.sv
// Waveform lookup between phase accumulator and DAC: cosine, triangle, pulse and
// double-buffered AWG. Mode, duty and bank changes only land on a phase wrap or an idle cycle.
module dds_wave_engine #(
  parameter int PW = 8,
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic [1:0]    sel,
  input  logic [PW-1:0] addr,
  input  logic [PW-1:0] duty,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          swap_req,
  output logic          swap_ack,
  output logic [1:0]    act_sel,
  output logic          act_bank,
  output logic [DW-1:0] dout,
  output logic          dout_vld
);

  localparam int  QD   = 2 ** (PW - 2);
  localparam int  AD   = 2 ** PW;
  localparam int  AMP  = 2 ** (DW - 1) - 1;
  localparam real PI   = 3.14159265358979323846;

  // Quarter-wave cosine table sampled at bin centres, so the fold is symmetric.
  logic [DW-2:0] cos_rom [QD];

  for (genvar gi = 0; gi < QD; gi++) begin : g_rom
    localparam real ANG = 2.0 * PI * ($itor(gi) + 0.5) / $itor(AD);
    localparam int  VAL = $rtoi($itor(AMP) * $cos(ANG) + 0.5);
    assign cos_rom[gi] = VAL[DW-2:0];
  end

  function automatic logic [DW-1:0] cos_fold(input logic [1:0] q, input logic [DW-2:0] mag);
    logic [DW-1:0] half;
    logic [DW-1:0] m;
    half = {1'b1, {(DW-1){1'b0}}};
    m    = {1'b0, mag};
    return (q == 2'd0 || q == 2'd3) ? half + m : half - m;
  endfunction

  logic [PW-1:0] addr_prev;
  logic [PW-1:0] duty_lat;
  logic          pend;

  logic          wrap;
  logic          commit;
  logic          do_swap;
  logic          rd_bank;
  logic [1:0]    sel_eff;
  logic [PW-1:0] duty_eff;

  assign wrap     = en && (addr < addr_prev);
  assign commit   = wrap || !en;
  assign sel_eff  = commit ? sel : act_sel;
  assign duty_eff = commit ? duty : duty_lat;
  assign do_swap  = commit && (pend || swap_req);
  // The sample taken in the commit cycle already reads the newly selected bank.
  assign rd_bank  = act_bank ^ do_swap;

  logic [1:0]    q;
  logic [PW-3:0] f;
  logic [PW-3:0] idx;
  logic [PW-2:0] t;
  logic [DW-1:0] tri_w;

  assign q   = addr[PW-1:PW-2];
  assign f   = addr[PW-3:0];
  assign idx = q[0] ? ~f : f;
  assign t   = addr[PW-1] ? ~addr[PW-2:0] : addr[PW-2:0];

  if (DW > PW - 1) begin : g_tri_pad
    assign tri_w = {t, {(DW-PW+1){1'b0}}};
  end else begin : g_tri_cut
    assign tri_w = t[PW-2 -: DW];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_prev <= '0;
      duty_lat  <= '0;
      pend      <= 1'b0;
      act_sel   <= 2'd0;
      act_bank  <= 1'b0;
      swap_ack  <= 1'b0;
    end else begin
      if (en) addr_prev <= addr;
      if (commit) begin
        act_sel  <= sel;
        duty_lat <= duty;
      end
      swap_ack <= do_swap;
      if (do_swap) begin
        act_bank <= ~act_bank;
        pend     <= 1'b0;
      end else begin
        pend <= pend | swap_req;
      end
    end
  end

  // Both banks share one array; writes target the shadow bank as seen before any swap.
  logic [DW-1:0] awg_mem [2*AD];
  logic [DW-1:0] ram_p1;

  always_ff @(posedge clk) begin
    ram_p1 <= awg_mem[{rd_bank, addr}];
    if (wr_en) awg_mem[{~act_bank, wr_addr}] <= wr_data;
  end

  // Stage 1: table read, quadrant and mode capture
  logic          vld_p1;
  logic [1:0]    mode_p1;
  logic [1:0]    q_p1;
  logic [DW-2:0] rom_p1;
  logic [DW-1:0] tri_p1;
  logic          pls_p1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1  <= 1'b0;
      mode_p1 <= 2'd0;
      q_p1    <= 2'd0;
      rom_p1  <= '0;
      tri_p1  <= '0;
      pls_p1  <= 1'b0;
    end else begin
      vld_p1 <= en;
      if (en) begin
        mode_p1 <= sel_eff;
        q_p1    <= q;
        rom_p1  <= cos_rom[idx];
        tri_p1  <= tri_w;
        pls_p1  <= addr < duty_eff;
      end
    end
  end

  logic [DW-1:0] smp;

  always_comb begin
    smp = '0;
    case (mode_p1)
      2'd0:    smp = cos_fold(q_p1, rom_p1);
      2'd1:    smp = tri_p1;
      2'd2:    smp = {DW{pls_p1}};
      default: smp = ram_p1;
    endcase
  end

  // Stage 2: output register, held while idle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= vld_p1;
      if (vld_p1) dout <= smp;
    end
  end

endmodule

// File: tb/tb_dds_wave_engine.sv
// Directed sweeps plus random traffic for dds_wave_engine, checked against a
// waveform-level reference model.
module tb_dds_wave_engine;
  localparam int PW = 8;
  localparam int DW = 10;
  localparam int AD = 2 ** PW;
  localparam int FS = 2 ** DW - 1;

  logic          clk;
  logic          rstn;
  logic          en;
  logic [1:0]    sel;
  logic [PW-1:0] addr;
  logic [PW-1:0] duty;
  logic          wr_en;
  logic [PW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          swap_req;
  logic          swap_ack;
  logic [1:0]    act_sel;
  logic          act_bank;
  logic [DW-1:0] dout;
  logic          dout_vld;

  dds_wave_engine #(.PW(PW), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .en(en), .sel(sel), .addr(addr), .duty(duty),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .swap_req(swap_req),
    .swap_ack(swap_ack), .act_sel(act_sel), .act_bank(act_bank),
    .dout(dout), .dout_vld(dout_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state: committed settings, bank contents and a two-deep sample delay.
  int m_sel, m_duty, m_bank, m_pend, m_prev;
  int awg [2][AD];
  int p1_vld, p1_val, o_vld, o_val, e_ack;

  function automatic int wave(input int s, input int a, input int d, input int ram);
    real v;
    case (s)
      0: begin
        v = $itor(2 ** (DW - 1) - 1) * $cos(2.0 * 3.14159265358979323846 * ($itor(a) + 0.5) / $itor(AD));
        return 2 ** (DW - 1) + ((v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5));
      end
      1: return ((a < AD / 2) ? a : (AD - 1 - a)) * (2 ** (DW - PW + 1));
      2: return (a < d) ? FS : 0;
      default: return ram;
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_duty = 0; m_bank = 0; m_pend = 0; m_prev = 0;
    p1_vld = 0; p1_val = 0; o_vld = 0; o_val = 0; e_ack = 0;
  endtask

  task automatic chk_all();
    chk("dout_vld", int'(dout_vld), o_vld);
    chk("dout", int'(dout), o_val);
    chk("act_sel", int'(act_sel), m_sel);
    chk("act_bank", int'(act_bank), m_bank);
    chk("swap_ack", int'(swap_ack), e_ack);
  endtask

  task automatic cycle();
    bit wrap, commit, dsw;
    int es, ed, rb, smp;
    wrap   = en && (int'(addr) < m_prev);
    commit = wrap || !en;
    es     = commit ? int'(sel) : m_sel;
    ed     = commit ? int'(duty) : m_duty;
    dsw    = commit && (m_pend != 0 || swap_req);
    rb     = dsw ? 1 - m_bank : m_bank;
    smp    = wave(es, int'(addr), ed, awg[rb][addr]);
    if (wr_en) awg[1 - m_bank][wr_addr] = int'(wr_data);
    if (commit) begin m_sel = int'(sel); m_duty = int'(duty); end
    if (dsw) begin m_bank = 1 - m_bank; m_pend = 0; end
    else if (swap_req) m_pend = 1;
    e_ack = dsw ? 1 : 0;
    if (en) m_prev = int'(addr);
    o_vld = p1_vld;
    if (p1_vld != 0) o_val = p1_val;
    p1_vld = en ? 1 : 0;
    p1_val = smp;
    @(posedge clk);
    #1;
    chk_all();
  endtask

  initial begin
    int a;
    rstn = 1'b1; en = 1'b0; sel = 2'd0; addr = '0; duty = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
    model_reset();
    #2 rstn = 1'b0;
    #1;
    chk("rst_dout", int'(dout), 0);
    chk("rst_vld", int'(dout_vld), 0);
    chk("rst_ack", int'(swap_ack), 0);
    chk("rst_sel", int'(act_sel), 0);
    chk("rst_bank", int'(act_bank), 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    cycle();
    // Cosine sweep
    en = 1'b1;
    for (int k = 0; k < AD; k++) begin
      addr = PW'(k);
      cycle();
      if (k == 0) chk("cos_vld_lat1", int'(dout_vld), 0);
      if (k == 1) begin
        chk("cos_vld_lat2", int'(dout_vld), 1);
        chk("cos_a0", int'(dout), 1023);
      end
      if (k == 65) chk("cos_a64", int'(dout), 506);
      if (k == 129) chk("cos_a128", int'(dout), 1);
    end

    // Triangle sweep, committed at the wrap
    sel = 2'd1;
    for (int k = 0; k <= AD; k++) begin
      addr = PW'(k % AD);
      cycle();
      if (k == 0) chk("tri_commit", int'(act_sel), 1);
      if (k == 1) chk("tri_a0", int'(dout), 0);
      if (k == 128) chk("tri_a127", int'(dout), 1016);
      if (k == 129) chk("tri_a128", int'(dout), 1016);
      if (k == AD) chk("tri_a255", int'(dout), 0);
    end

    // Pulse: selection made mid-sweep waits for the wrap
    en = 1'b0; sel = 2'd0; duty = '0;
    cycle();
    en = 1'b1;
    for (int k = 0; k < AD; k++) begin
      addr = PW'(k);
      if (k == 100) begin sel = 2'd2; duty = PW'(64); end
      cycle();
      if (k == AD - 1) chk("pls_hold_sel", int'(act_sel), 0);
    end
    for (int k = 0; k <= 70; k++) begin
      addr = PW'(k);
      if (k == 10) begin sel = 2'd1; duty = PW'(200); end
      cycle();
      if (k == 0) chk("pls_commit", int'(act_sel), 2);
      if (k == 1) chk("pls_a0", int'(dout), 1023);
      if (k == 64) chk("pls_a63", int'(dout), 1023);
      if (k == 65) chk("pls_a64", int'(dout), 0);
    end

    // AWG: clear both banks, then play zeros while loading a ramp into the shadow
    sel = 2'd2; duty = PW'(64); wr_en = 1'b1; wr_data = '0;
    for (int k = 0; k < AD; k++) begin
      addr = PW'(k); wr_addr = PW'(k); swap_req = (k == 200);
      cycle();
    end
    for (int k = 0; k < AD; k++) begin
      addr = PW'(k); swap_req = (k == 200);
      wr_en = (k != 0); wr_addr = PW'(k - 1);
      if (k == 10) sel = 2'd3;
      cycle();
      if (k == 0) begin
        chk("awg_sw1_ack", int'(swap_ack), 1);
        chk("awg_sw1_bank", int'(act_bank), 1);
      end
    end
    wr_en = 1'b1;
    for (int k = 0; k < AD; k++) begin
      addr = PW'(k); swap_req = (k == 150 || k == 160);
      wr_addr = (k == 0) ? PW'(AD - 1) : PW'(k);
      wr_data = (k == 0) ? '0 : DW'(k * 4);
      cycle();
      if (k == 200) chk("awg_bank0_play", int'(dout), 0);
      if (k == AD - 1) begin
        chk("awg_no_early_ack", int'(swap_ack), 0);
        chk("awg_bank_held", int'(act_bank), 0);
      end
    end
    wr_en = 1'b0; swap_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      addr = PW'(k);
      cycle();
      if (k == 0) begin
        chk("awg_sw_ack", int'(swap_ack), 1);
        chk("awg_sw_bank", int'(act_bank), 1);
      end
      if (k == 1) chk("awg_single_ack", int'(swap_ack), 0);
      if (k == 5) chk("awg_ramp4", int'(dout), 16);
      if (k == 19) chk("awg_ramp18", int'(dout), 72);
    end

    // Enable drop: drain, hold, and immediate commits
    en = 1'b0;
    cycle();
    chk("idle_vld1", int'(dout_vld), 1);
    chk("idle_last", int'(dout), 76);
    cycle();
    chk("idle_vld0", int'(dout_vld), 0);
    chk("idle_hold", int'(dout), 76);
    sel = 2'd1;
    cycle();
    chk("idle_sel", int'(act_sel), 1);
    chk("idle_hold2", int'(dout), 76);

    // Random traffic
    a = 0;
    for (int n = 0; n < 3000; n++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) a = int'($urandom_range(0, AD - 1));
      else a = (a + int'($urandom_range(0, 9))) % AD;
      addr = PW'(a);
      sel = 2'($urandom_range(0, 3));
      duty = ($urandom_range(0, 7) == 0) ? '0 : PW'($urandom_range(0, AD - 1));
      swap_req = ($urandom_range(0, 19) == 0);
      wr_en = ($urandom_range(0, 1) != 0);
      wr_addr = PW'($urandom_range(0, AD - 1));
      wr_data = DW'($urandom_range(0, FS));
      cycle();
    end

    // Reset mid-sweep with a swap pending
    en = 1'b1; sel = 2'd3; wr_en = 1'b0; swap_req = 1'b0;
    for (int k = 0; k <= 60; k++) begin
      addr = PW'(k); swap_req = (k == 50);
      cycle();
    end
    swap_req = 1'b0;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_dout", int'(dout), 0);
    chk("mid_rst_vld", int'(dout_vld), 0);
    chk("mid_rst_ack", int'(swap_ack), 0);
    chk("mid_rst_sel", int'(act_sel), 0);
    chk("mid_rst_bank", int'(act_bank), 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    for (int k = 61; k < AD + 20; k++) begin
      addr = PW'(k % AD);
      cycle();
      if (k == AD) begin
        chk("post_rst_no_ack", int'(swap_ack), 0);
        chk("post_rst_bank", int'(act_bank), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
